// File: rtl/tree_fanout_node.sv
// Interior node of the module-hierarchy tree: broadcasts one parent command to the
// enabled children, gathers one response from each, and returns a single reduced reply.
module tree_fanout_node #(
    parameter int FANOUT  = 10,
    parameter int DATA_W  = 16,
    parameter int SUM_W   = DATA_W + $clog2(FANOUT + 1),
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FANOUT-1:0]             child_en,
    input  logic                          up_req_valid,
    output logic                          up_req_ready,
    input  logic [DATA_W-1:0]             up_req_data,
    output logic [FANOUT-1:0]             dn_req_valid,
    input  logic [FANOUT-1:0]             dn_req_ready,
    output logic [DATA_W-1:0]             dn_req_data,
    input  logic [FANOUT-1:0]             dn_rsp_valid,
    output logic [FANOUT-1:0]             dn_rsp_ready,
    input  logic [FANOUT*DATA_W-1:0]      dn_rsp_data,
    output logic                          up_rsp_valid,
    input  logic                          up_rsp_ready,
    output logic [SUM_W-1:0]              up_rsp_sum,
    output logic [$clog2(FANOUT+1)-1:0]   up_rsp_cnt,
    output logic [FANOUT-1:0]             up_rsp_miss,
    output logic                          up_rsp_tmo
);

    localparam int CNT_W = $clog2(FANOUT + 1);
    // Timer only ever holds 0..TIMEOUT-1; the last value triggers the forced completion.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BCAST, GATHER, RESP} state_t;

    state_t             state_q, state_d;
    logic [FANOUT-1:0]  en_mask_q, en_mask_d;
    logic [FANOUT-1:0]  sent_q, sent_d;
    logic [FANOUT-1:0]  done_q, done_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;
    logic [SUM_W-1:0]   rsp_sum_q, rsp_sum_d;
    logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic [FANOUT-1:0]  rsp_miss_q, rsp_miss_d;
    logic               rsp_tmo_q, rsp_tmo_d;
    logic [FANOUT-1:0]  req_acc, rsp_acc;

    function automatic logic [SUM_W-1:0] acc_sum(input logic [FANOUT-1:0] acc,
                                                 input logic [FANOUT*DATA_W-1:0] data);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < FANOUT; i++)
            if (acc[i]) s = s + SUM_W'(data[i*DATA_W +: DATA_W]);
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] acc_count(input logic [FANOUT-1:0] acc);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < FANOUT; i++)
            if (acc[i]) c = c + CNT_W'(1);
        return c;
    endfunction

    // Response ready uses the registered sent mask, so a child's command and response never share a cycle.
    assign up_req_ready = rst_n & (state_q == IDLE);
    assign dn_req_valid = (state_q == BCAST) ? (en_mask_q & ~sent_q) : '0;
    assign dn_rsp_ready = ((state_q == BCAST) || (state_q == GATHER)) ? (en_mask_q & sent_q & ~done_q) : '0;
    assign dn_req_data  = req_data_q;
    assign req_acc      = dn_req_valid & dn_req_ready;
    assign rsp_acc      = dn_rsp_valid & dn_rsp_ready;
    assign up_rsp_valid = (state_q == RESP);
    assign up_rsp_sum   = rsp_sum_q;
    assign up_rsp_cnt   = rsp_cnt_q;
    assign up_rsp_miss  = rsp_miss_q;
    assign up_rsp_tmo   = rsp_tmo_q;

    always_comb begin
        state_d    = state_q;
        en_mask_d  = en_mask_q;
        sent_d     = sent_q;
        done_d     = done_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        req_data_d = req_data_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cnt_d  = rsp_cnt_q;
        rsp_miss_d = rsp_miss_q;
        rsp_tmo_d  = rsp_tmo_q;
        unique case (state_q)
            IDLE: begin
                if (up_req_valid) begin
                    req_data_d = up_req_data;
                    en_mask_d  = child_en;
                    sent_d     = '0;
                    done_d     = '0;
                    sum_d      = '0;
                    cnt_d      = '0;
                    timer_d    = '0;
                    if (child_en == '0) begin
                        state_d    = RESP;
                        rsp_sum_d  = '0;
                        rsp_cnt_d  = '0;
                        rsp_miss_d = '0;
                        rsp_tmo_d  = 1'b0;
                    end else begin
                        state_d = BCAST;
                    end
                end
            end
            BCAST, GATHER: begin
                sent_d  = sent_q | req_acc;
                done_d  = done_q | rsp_acc;
                sum_d   = sum_q + acc_sum(rsp_acc, dn_rsp_data);
                cnt_d   = cnt_q + acc_count(rsp_acc);
                timer_d = timer_q + TMR_W'(1);
                // Completion wins over a timeout landing in the same cycle.
                if ((state_q == GATHER) && (done_d == en_mask_q)) begin
                    state_d    = RESP;
                    rsp_sum_d  = sum_d;
                    rsp_cnt_d  = cnt_d;
                    rsp_miss_d = '0;
                    rsp_tmo_d  = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d    = RESP;
                    rsp_sum_d  = sum_d;
                    rsp_cnt_d  = cnt_d;
                    rsp_miss_d = en_mask_q & ~done_d;
                    rsp_tmo_d  = 1'b1;
                end else if ((state_q == BCAST) && ((sent_d & en_mask_q) == en_mask_q)) begin
                    state_d = GATHER;
                end
            end
            RESP: begin
                if (up_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_mask_q  <= '0;
            sent_q     <= '0;
            done_q     <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            req_data_q <= '0;
            rsp_sum_q  <= '0;
            rsp_cnt_q  <= '0;
            rsp_miss_q <= '0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_mask_q  <= en_mask_d;
            sent_q     <= sent_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            req_data_q <= req_data_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cnt_q  <= rsp_cnt_d;
            rsp_miss_q <= rsp_miss_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

endmodule

// File: doc/tree_fanout_node.md
# tree_fanout_node

Parametrised interior node for the module-hierarchy tree. It accepts one command from its parent, broadcasts it to up to FANOUT child instances with per-child valid/ready handshakes, and gathers one response per enabled child. It returns a single reduced response (sum, responder count, missing-child mask, timeout flag) upstream. Nodes compose into trees of arbitrary width and depth, replacing fixed ten-way hand-instantiated hierarchy levels.

## Interface
Parameters:
- FANOUT, 10, number of child ports (1..32)
- DATA_W, 16, command/response data width
- SUM_W, DATA_W+$clog2(FANOUT+1), reduced-sum width
- TIMEOUT, 255, cycles allowed in BCAST+GATHER before forced completion (>=1)

Ports (reset is asynchronous, active-low):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- child_en  in  FANOUT  per-child enable; sampled on upstream command accept
- up_req_valid  in  1  parent command valid
- up_req_ready  out  1  node can accept a command
- up_req_data  in  DATA_W  command payload
- dn_req_valid  out  FANOUT  per-child command valid
- dn_req_ready  in  FANOUT  per-child command ready
- dn_req_data  out  DATA_W  registered command payload, shared by all children
- dn_rsp_valid  in  FANOUT  per-child response valid
- dn_rsp_ready  out  FANOUT  per-child response ready
- dn_rsp_data  in  FANOUT*DATA_W  child responses; child i occupies bits [i*DATA_W +: DATA_W]
- up_rsp_valid  out  1  reduced response valid
- up_rsp_ready  in  1  parent accepts response
- up_rsp_sum  out  SUM_W  zero-extended sum of gathered child data
- up_rsp_cnt  out  $clog2(FANOUT+1)  number of children that responded
- up_rsp_miss  out  FANOUT  enabled children that did not respond
- up_rsp_tmo  out  1  transaction ended by timeout

## Operation
- States: IDLE, BCAST, GATHER, RESP.
- IDLE: up_req_ready=1. On up_req_valid, latch up_req_data, en_mask<=child_en; clear sent_mask, done_mask, sum, cnt, and timer.
  - If child_en==0, go to RESP (sum 0, cnt 0, miss 0, tmo 0).
  - Otherwise go to BCAST.
- BCAST: dn_req_valid[i] = en_mask[i] & ~sent_mask[i]. On dn_req_valid[i]&dn_req_ready[i], set sent_mask[i]. When all enabled bits are sent, go to GATHER.
- Responses are accepted in BCAST and GATHER. dn_rsp_ready[i] = en_mask[i] & sent_mask[i] & ~done_mask[i], using the registered sent_mask.
  - A response is never accepted in the same cycle as that child's command.
  - On each response handshake: sum += data, cnt += 1, set done_mask[i].
  - Multiple children may respond in one cycle; all are summed.
  - Duplicate or unexpected dn_rsp_valid is ignored because ready is low.
- GATHER: when done_mask==en_mask (including responses accepted this cycle), go to RESP.
- Timeout: timer increments every cycle in BCAST/GATHER. If it reaches TIMEOUT before completion, go to RESP with tmo=1 and miss=en_mask & ~done_mask. Responses accepted in the timeout cycle still count. Completion and timeout in the same cycle count as completion, tmo=0.
- RESP: up_rsp_* outputs are registered and held stable while up_rsp_valid=1 and up_rsp_ready=0. On handshake, go to IDLE. Late child responses are not accepted (ready=0).
- Sum cannot overflow: SUM_W covers FANOUT*(2^DATA_W-1).
- rst_n low at any time, including mid-transaction: return to IDLE immediately; all masks, counters and outputs clear.

## Timing
- Reset values: up_req_ready=0 while rst_n low, 1 in IDLE after reset release. dn_req_valid=0, dn_rsp_ready=0, up_rsp_valid=0, up_rsp_sum=0, up_rsp_cnt=0, up_rsp_miss=0, up_rsp_tmo=0. dn_req_data=0.
- Command accepted at cycle 0 -> dn_req_valid at cycle 1.
- Child i command accepted at cycle c -> its response may be accepted at cycle c+1 or later.
- Last response accepted at cycle k -> up_rsp_valid at cycle k+1.
- Minimum latency, all children ready and responding immediately: up_rsp_valid at cycle 3.
- All children disabled: up_rsp_valid at cycle 1.
- Timeout: up_rsp_valid exactly TIMEOUT+1 cycles after command accept when responses are incomplete.
- Throughput: after the up_rsp handshake at cycle r, up_req_ready=1 at cycle r+1. No overlap between transactions.

## Test plan
- FANOUT=10, all enabled, all ready. Child i responds with i+1 one cycle after its command -> up_rsp_valid at cycle 3, sum=55, cnt=10, miss=0, tmo=0.
- child_en=10'b0000000101, staggered dn_req_ready (child 2 ready 4 cycles late) -> dn_req_valid only on bits 0 and 2. cnt=2, sum equals the two responses, disabled children never see valid.
- child_en=0 -> up_rsp_valid at cycle 1, sum=0, cnt=0, up_rsp_tmo=0.
- TIMEOUT=20, child 7 never responds -> up_rsp_valid at cycle 21, tmo=1, miss=10'b0010000000, cnt=9.
- All children 0xFFFF with DATA_W=16 -> sum=655350 (SUM_W=20), no wrap. Hold up_rsp_ready low 5 cycles -> outputs stable throughout.
- Assert rst_n low in GATHER with 4 responses pending -> all outputs zero asynchronously. After release, a new command completes normally with no residue from the aborted transaction.
